sprite_scheduler: RTL and testbench

Frame-paced scheduler that shares the single VGA adapter write port among up to N sprite engines (player, alien, bullet). Once per frame tick it erases every enabled sprite in index order, then draws every enabled sprite, handshaking with each engine through its draw/erase strobes and finish pulse. It muxes the granted engine's pixel stream onto the VGA adapter. It also flags frame overruns and unresponsive engines.

---
 rtl/sprite_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_sprite_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sprite_scheduler
// Purpose : Frame-paced erase/draw arbiter sharing one VGA write port among
//           N sprite engines, with overrun and engine-timeout flags.
// Rev     : 1.0
// ============================================================================
module sprite_scheduler #(
  parameter int N_SPRITES    = 3,
  parameter int FRAME_CYCLES = 833333,
  parameter int TIMEOUT      = 63
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SPRITES-1:0]   spr_enable,
  input  logic [9*N_SPRITES-1:0] spr_x,
  input  logic [8*N_SPRITES-1:0] spr_y,
  input  logic [3*N_SPRITES-1:0] spr_colour,
  input  logic [N_SPRITES-1:0]   spr_done,
  output logic [N_SPRITES-1:0]   draw_signal,
  output logic [N_SPRITES-1:0]   erase_signal,
  output logic [8:0]             vga_x,
  output logic [7:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int FC_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int WC_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPRITES - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_CYCLES - 1);
  localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ERASE_ISSUE = 3'd1,
    ERASE_WAIT  = 3'd2,
    DRAW_ISSUE  = 3'd3,
    DRAW_WAIT   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WC_W-1:0]        wcnt_q, wcnt_d;
  logic [FC_W-1:0]        fcnt_q;
  logic                   pending_q, pending_d;
  logic [N_SPRITES-1:0]   erase_q, erase_d;
  logic [N_SPRITES-1:0]   draw_q, draw_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;

  logic                   tick;
  logic                   in_wait;
  logic                   in_draw;
  logic                   advance;

  logic [8:0] x_arr [N_SPRITES];
  logic [7:0] y_arr [N_SPRITES];
  logic [2:0] c_arr [N_SPRITES];

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_unpack
    assign x_arr[g] = spr_x[9*g +: 9];
    assign y_arr[g] = spr_y[8*g +: 8];
    assign c_arr[g] = spr_colour[3*g +: 3];
  end

  assign tick    = (fcnt_q == FC_LAST);
  assign in_wait = (state_q == ERASE_WAIT) || (state_q == DRAW_WAIT);
  assign in_draw = (state_q == DRAW_ISSUE) || (state_q == DRAW_WAIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fcnt_q <= '0;
    end else if (tick) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wcnt_q       <= '0;
      pending_q    <= 1'b0;
      erase_q      <= '0;
      draw_q       <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      pending_q    <= pending_d;
      erase_q      <= erase_d;
      draw_q       <= draw_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wcnt_d       = wcnt_q;
    pending_d    = pending_q;
    erase_d      = '0;
    draw_d       = '0;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    timeout_d    = timeout_q;
    advance      = 1'b0;

    // A tick during a pass queues at most one follow-up pass.
    if (tick && (state_q != IDLE) && !pending_q) begin
      pending_d = 1'b1;
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tick || pending_q) begin
          idx_d     = '0;
          pending_d = 1'b0;
          state_d   = ERASE_ISSUE;
        end
      end
      ERASE_ISSUE, DRAW_ISSUE: begin
        if (spr_enable[idx_q]) begin
          if (in_draw) draw_d[idx_q] = 1'b1;
          else         erase_d[idx_q] = 1'b1;
          wcnt_d  = '0;
          state_d = in_draw ? DRAW_WAIT : ERASE_WAIT;
        end else begin
          advance = 1'b1;
        end
      end
      ERASE_WAIT, DRAW_WAIT: begin
        if (spr_done[idx_q]) begin
          advance = 1'b1;
        end else if (wcnt_q == WC_MAX) begin
          advance   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (idx_q < LAST_IDX) begin
        idx_d   = idx_q + 1'b1;
        state_d = in_draw ? DRAW_ISSUE : ERASE_ISSUE;
      end else if (!in_draw) begin
        idx_d   = '0;
        state_d = DRAW_ISSUE;
      end else begin
        idx_d        = '0;
        state_d      = IDLE;
        frame_done_d = 1'b1;
      end
    end
  end

  assign erase_signal = erase_q;
  assign draw_signal  = draw_q;
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_q;
  assign vga_plot     = in_wait;
  assign vga_x        = in_wait ? x_arr[idx_q] : 9'd0;
  assign vga_y        = in_wait ? y_arr[idx_q] : 8'd0;
  assign vga_colour   = in_wait ? c_arr[idx_q] : 3'd0;

endmodule
`default_nettype wire

// File: tb/tb_sprite_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_scheduler
// Purpose : Randomized bench for sprite_scheduler against a pass-schedule model.
// Rev     : 1.0
// ============================================================================
module tb_sprite_scheduler;

  localparam int N    = 3;
  localparam int FC   = 150;
  localparam int TO   = 63;
  localparam int L    = 700;
  localparam int LM   = L + 512;
  localparam int DEAD = 1000;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   spr_enable = '0;
  logic [9*N-1:0] spr_x = '0;
  logic [8*N-1:0] spr_y = '0;
  logic [3*N-1:0] spr_colour = '0;
  logic [N-1:0]   spr_done = '0;
  logic [N-1:0]   draw_signal, erase_signal;
  logic [8:0]     vga_x;
  logic [7:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot, frame_done, overrun, timeout_err;

  sprite_scheduler #(.N_SPRITES(N), .FRAME_CYCLES(FC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .spr_enable(spr_enable), .spr_x(spr_x),
    .spr_y(spr_y), .spr_colour(spr_colour), .spr_done(spr_done),
    .draw_signal(draw_signal), .erase_signal(erase_signal),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .frame_done(frame_done), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int cyc, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Expected per-cycle behaviour, derived from the pass schedule.
  int           dly [N];
  logic [N-1:0] en_arr  [LM];
  logic [N-1:0] x_erase [LM];
  logic [N-1:0] x_draw  [LM];
  bit           x_fd    [LM];
  bit           x_plot  [LM];
  bit           x_ph    [LM];
  bit           x_ovr   [LM];
  bit           x_to    [LM];
  int           x_g     [LM];

  task automatic build_model();
    int  c, t, w;
    bit  pend;
    for (int k = 0; k < LM; k++) begin
      x_erase[k] = '0; x_draw[k] = '0; x_fd[k] = 0; x_plot[k] = 0;
      x_ph[k] = 0; x_ovr[k] = 0; x_to[k] = 0; x_g[k] = -1;
    end
    c = 0;
    pend = 0;
    while (c < L) begin
      if (((c % FC) == FC - 1) || pend) begin
        pend = 0;
        t = c + 1;
        for (int ph = 0; ph < 2; ph++) begin
          for (int i = 0; i < N; i++) begin
            if (en_arr[t][i]) begin
              // done landing exactly on the timeout cycle still counts as done
              w = (dly[i] <= TO) ? dly[i] : TO;
              if (ph == 0) x_erase[t+1][i] = 1'b1;
              else         x_draw[t+1][i]  = 1'b1;
              for (int k = t + 1; k <= t + 1 + w; k++) begin
                x_plot[k] = 1; x_g[k] = i; x_ph[k] = (ph == 1);
              end
              if (dly[i] > TO)
                for (int k = t + 2 + w; k < LM; k++) x_to[k] = 1;
              t = t + 2 + w;
            end else begin
              t = t + 1;
            end
          end
        end
        for (int k = c + 1; k < t; k++) begin
          if ((k % FC) == FC - 1) begin
            pend = 1;
            for (int m = k + 1; m < LM; m++) x_ovr[m] = 1;
          end
        end
        x_fd[t] = 1;
        c = t;
      end else begin
        c++;
      end
    end
  endtask

  task automatic run_scenario(input int d0, input int d1, input int d2,
                              input logic [N-1:0] en, input bit rnd_en,
                              input bit spur, input bit rst_mid);
    int done_at [N];
    int rst_at;
    logic [N-1:0] cur_en;
    logic [20:0] exp_v;
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
    cur_en = en;
    for (int k = 0; k < LM; k++) begin
      if (rnd_en && (k % 40 == 0)) cur_en = N'($urandom);
      en_arr[k] = cur_en;
    end
    build_model();
    rst_at = -1;
    if (rst_mid) begin
      for (int k = 0; k < L; k++) begin
        if (rst_at < 0 && x_plot[k] && x_ph[k] && x_g[k] == 1) rst_at = k + 2;
      end
      if (rst_at < 0) chk("rst_window", 0, 64'd0, 64'd1);
    end

    reset    = 1'b0;
    spr_done = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) done_at[i] = -1;

    for (int c = 0; c < L; c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < N; i++)
        if (erase_signal[i] || draw_signal[i])
          done_at[i] = (dly[i] < DEAD) ? c + dly[i] : -1;
      spr_enable = en_arr[c];
      for (int i = 0; i < N; i++) begin
        spr_x[9*i +: 9]      = 9'($urandom);
        spr_y[8*i +: 8]      = 8'($urandom);
        spr_colour[3*i +: 3] = 3'($urandom);
        spr_done[i] = (done_at[i] == c) ||
                      (spur && !(x_plot[c] && x_g[c] == i) && ($urandom_range(0, 7) == 0));
      end
      if (c == rst_at) reset = 1'b0;
      #1;
      chk("strobes_flags", c,
          64'({erase_signal, draw_signal, frame_done, overrun, timeout_err}),
          64'({x_erase[c], x_draw[c], x_fd[c], x_ovr[c], x_to[c]}));
      exp_v = '0;
      if (x_plot[c])
        exp_v = {1'b1, spr_x[9*x_g[c] +: 9], spr_y[8*x_g[c] +: 8], spr_colour[3*x_g[c] +: 3]};
      chk("vga_mux", c, 64'({vga_plot, vga_x, vga_y, vga_colour}), 64'(exp_v));
      if (c == rst_at) begin
        @(negedge clk);
        #1;
        chk("mid_pass_reset", c + 1,
            64'({erase_signal, draw_signal, frame_done, overrun, timeout_err,
                 vga_plot, vga_x, vga_y, vga_colour}), 64'd0);
        break;
      end
    end
  endtask

  initial begin
    int pick [8];
    pick[0] = 1;  pick[1] = 7;  pick[2] = 18; pick[3] = 62;
    pick[4] = 63; pick[5] = 64; pick[6] = 70; pick[7] = DEAD;

    run_scenario(10, 20, 30, 3'b111, 0, 0, 0);
    run_scenario(12, 7, 25, 3'b101, 0, 1, 0);
    run_scenario(5, DEAD, 8, 3'b111, 0, 1, 0);
    run_scenario(60, 60, 60, 3'b111, 0, 1, 0);
    run_scenario(63, 64, 1, 3'b111, 0, 1, 0);
    run_scenario(9, 15, 11, 3'b111, 0, 1, 1);
    run_scenario(4, 6, 3, 3'b111, 0, 0, 0);
    for (int s = 0; s < 4; s++)
      run_scenario(pick[$urandom_range(0, 7)], pick[$urandom_range(0, 7)],
                   pick[$urandom_range(0, 7)], 3'b111, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
